// File: rtl/dma_controller_pkg.sv
// rtl/dma_controller_pkg.sv - state encodings and line geometry for the DMA controller
package dma_controller_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INT      = 3'd1;
    localparam logic [2:0] ST_WAIT_CMD = 3'd2;
    localparam logic [2:0] ST_REQ      = 3'd3;
    localparam logic [2:0] ST_FETCH    = 3'd4;
    localparam logic [2:0] ST_WRITE    = 3'd5;
    localparam logic [2:0] ST_NEXT     = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    localparam int DMA_LINE_WORDS = 4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_INT      = ST_INT,
        S_WAIT_CMD = ST_WAIT_CMD,
        S_REQ      = ST_REQ,
        S_FETCH    = ST_FETCH,
        S_WRITE    = ST_WRITE,
        S_NEXT     = ST_NEXT,
        S_DONE     = ST_DONE
    } dma_state_t;

endpackage

// File: rtl/dma_controller.sv
// rtl/dma_controller.sv - bus-mastering DMA engine writing device lines into data memory
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int                  WORD_SIZE   = 16,
    parameter logic [WORD_SIZE-1:0] BASE_ADDR  = 16'h01F4,
    parameter int                  LENGTH      = 12,
    parameter int                  MEM_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 dev_req,
    input  logic                                 dev_valid,
    input  logic [DMA_LINE_WORDS*WORD_SIZE-1:0]  dev_data,
    output logic                                 dev_ready,
    output logic                                 dma_start_int,
    input  logic                                 cmd,
    output logic                                 BR,
    input  logic                                 BG,
    output logic [WORD_SIZE-1:0]                 d_address,
    output logic                                 d_writeM,
    output logic [DMA_LINE_WORDS*WORD_SIZE-1:0]  d_data,
    output logic                                 dma_end_int
);

    localparam int NUM_BLOCKS = LENGTH / DMA_LINE_WORDS;
    localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);
    localparam int LAT_W      = $clog2(MEM_LATENCY + 1);
    localparam int LINE_W     = DMA_LINE_WORDS * WORD_SIZE;

    dma_state_t           state;
    dma_state_t           state_next;
    logic [BLK_W-1:0]     blk;
    logic [BLK_W-1:0]     blk_inc;
    logic [LAT_W-1:0]     lat_cnt;
    logic [LINE_W-1:0]    line_buf;
    logic                 dev_req_q;
    logic                 dev_req_rise;

    assign blk_inc      = blk + 1'b1;
    assign dev_req_rise = dev_req && !dev_req_q;

    // State register plus the datapath registers owned by each state
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            blk       <= '0;
            lat_cnt   <= '0;
            line_buf  <= '0;
            dev_req_q <= 1'b0;
        end else begin
            state     <= state_next;
            dev_req_q <= dev_req;
            case (state)
                S_WAIT_CMD: blk <= '0;
                S_FETCH: begin
                    if (dev_valid) begin
                        line_buf <= dev_data;
                        lat_cnt  <= LAT_W'(MEM_LATENCY - 1);
                    end
                end
                S_WRITE: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_NEXT:  blk <= blk_inc;
                default: ;
            endcase
        end
    end

    // Next-state decode; BG is only looked at in REQ and between lines
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (dev_req_rise) state_next = S_INT;
            S_INT:      state_next = S_WAIT_CMD;
            S_WAIT_CMD: if (cmd) state_next = S_REQ;
            S_REQ:      if (BG) state_next = S_FETCH;
            S_FETCH:    if (dev_valid) state_next = S_WRITE;
            S_WRITE:    if (lat_cnt == '0) state_next = S_NEXT;
            S_NEXT: begin
                if (blk_inc == BLK_W'(NUM_BLOCKS)) begin
                    state_next = S_DONE;
                end else if (BG) begin
                    state_next = S_FETCH;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state so no input reaches an output
    always_comb begin
        dma_start_int = (state == S_INT);
        dma_end_int   = (state == S_DONE);
        dev_ready     = (state == S_FETCH);
        d_writeM      = (state == S_WRITE);
        BR            = (state == S_REQ) || (state == S_FETCH) ||
                        (state == S_WRITE) || (state == S_NEXT);
        d_address     = '0;
        d_data        = '0;
        if (state == S_WRITE) begin
            d_address = BASE_ADDR + (WORD_SIZE'(blk) << 2);
            d_data    = line_buf;
        end
    end

endmodule
